// File: rtl/demux_2bit_fifo.sv
// demux_2bit_fifo: steers a 2-bit valid/ready stream into one of two
// independently back-pressured channel FIFOs, each with an accept counter.
module demux_2bit_fifo #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       In_data,
  input  logic             In_signal,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [1:0]       Out1_data,
  output logic             Out1_valid,
  input  logic             Out1_ready,
  output logic [1:0]       Out2_data,
  output logic             Out2_valid,
  input  logic             Out2_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 1;

  // Index 0 is channel 1, index 1 is channel 2.
  logic [1:0]       mem_q  [2][DEPTH];
  logic [AW-1:0]    wptr_q [2];
  logic [AW-1:0]    wptr_d [2];
  logic [AW-1:0]    rptr_q [2];
  logic [AW-1:0]    rptr_d [2];
  logic [OW-1:0]    occ_q  [2];
  logic [OW-1:0]    occ_d  [2];
  logic [CNT_W-1:0] cnt_q  [2];
  logic [CNT_W-1:0] cnt_d  [2];
  logic             full   [2];
  logic             empty  [2];
  logic             push   [2];
  logic             pop    [2];

  // Fill-level flags per channel, decoded from the occupancy counters.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      full[c]  = (occ_q[c] == OW'(DEPTH));
      empty[c] = (occ_q[c] == '0);
    end
  end

  // Ready follows only the steering bit and FIFO state; no pop bypass on full.
  assign In_ready = In_signal ? !full[1] : !full[0];

  // Handshake qualification: a push goes only to the steered channel.
  always_comb begin
    push[0] = In_valid && !In_signal && !full[0];
    push[1] = In_valid &&  In_signal && !full[1];
    pop[0]  = Out1_ready && !empty[0];
    pop[1]  = Out2_ready && !empty[1];
  end

  // Next-state for pointers, occupancy and counters; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      occ_d[c]  = occ_q[c];
      cnt_d[c]  = cnt_q[c];
      if (push[c]) begin
        wptr_d[c] = wptr_q[c] + AW'(1);
        cnt_d[c]  = cnt_q[c] + CNT_W'(1);
      end
      if (pop[c]) begin
        rptr_d[c] = rptr_q[c] + AW'(1);
      end
      if (push[c] && !pop[c]) begin
        occ_d[c] = occ_q[c] + OW'(1);
      end else if (!push[c] && pop[c]) begin
        occ_d[c] = occ_q[c] - OW'(1);
      end
    end
  end

  // Control state register; reset empties both channels immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        occ_q[c]  <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        occ_q[c]  <= occ_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
    end
  end

  // Payload storage; stale entries are masked by the empty flag, so no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem_q[c][wptr_q[c]] <= In_data;
      end
    end
  end

  assign Out1_valid = !empty[0];
  assign Out2_valid = !empty[1];
  assign Out1_data  = empty[0] ? 2'b00 : mem_q[0][rptr_q[0]];
  assign Out2_data  = empty[1] ? 2'b00 : mem_q[1][rptr_q[1]];
  assign cnt1       = cnt_q[0];
  assign cnt2       = cnt_q[1];

endmodule

// File: tb/tb_demux_2bit_fifo.sv
// Directed bench for demux_2bit_fifo: table of per-cycle vectors plus
// hand-written sequences for asynchronous reset and counter wrap.
module tb_demux_2bit_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] In_data = 2'b00;
  logic       In_signal = 1'b0;
  logic       In_valid = 1'b0;
  logic       In_ready;
  logic [1:0] Out1_data;
  logic       Out1_valid;
  logic       Out1_ready = 1'b0;
  logic [1:0] Out2_data;
  logic       Out2_valid;
  logic       Out2_ready = 1'b0;
  logic [7:0] cnt1;
  logic [7:0] cnt2;

  // Second instance with narrow counters for the wrap test.
  logic [1:0] b_In_data = 2'b00;
  logic       b_In_signal = 1'b0;
  logic       b_In_valid = 1'b0;
  logic       b_In_ready;
  logic [1:0] b_Out1_data;
  logic       b_Out1_valid;
  logic       b_Out1_ready = 1'b0;
  logic [1:0] b_Out2_data;
  logic       b_Out2_valid;
  logic       b_Out2_ready = 1'b0;
  logic [1:0] b_cnt1;
  logic [1:0] b_cnt2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  demux_2bit_fifo #(.DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .In_data(In_data), .In_signal(In_signal), .In_valid(In_valid), .In_ready(In_ready),
    .Out1_data(Out1_data), .Out1_valid(Out1_valid), .Out1_ready(Out1_ready),
    .Out2_data(Out2_data), .Out2_valid(Out2_valid), .Out2_ready(Out2_ready),
    .cnt1(cnt1), .cnt2(cnt2)
  );

  demux_2bit_fifo #(.DEPTH(2), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .In_data(b_In_data), .In_signal(b_In_signal), .In_valid(b_In_valid), .In_ready(b_In_ready),
    .Out1_data(b_Out1_data), .Out1_valid(b_Out1_valid), .Out1_ready(b_Out1_ready),
    .Out2_data(b_Out2_data), .Out2_valid(b_Out2_valid), .Out2_ready(b_Out2_ready),
    .cnt1(b_cnt1), .cnt2(b_cnt2)
  );

  typedef struct {
    int iv;  int isig; int id;  int r1;  int r2;
    int eir; int e1v;  int e1d; int e2v; int e2d; int ec1; int ec2;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " In_ready"},   int'(In_ready),   v.eir);
    check({tag, " Out1_valid"}, int'(Out1_valid), v.e1v);
    check({tag, " Out1_data"},  int'(Out1_data),  v.e1d);
    check({tag, " Out2_valid"}, int'(Out2_valid), v.e2v);
    check({tag, " Out2_data"},  int'(Out2_data),  v.e2d);
    check({tag, " cnt1"},       int'(cnt1),       v.ec1);
    check({tag, " cnt2"},       int'(cnt2),       v.ec2);
  endtask

  initial begin
    // Expectations are the outputs seen before the row's clock edge.
    //           iv isig id r1 r2   eir e1v e1d e2v e2d c1 c2
    // steering
    vecs[0]  = '{1, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 2, 0, 0,   1, 1, 1, 0, 0, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 0,   1, 1, 1, 1, 2, 1, 1};
    vecs[3]  = '{0, 0, 0, 1, 1,   1, 1, 1, 1, 2, 1, 1};
    vecs[4]  = '{0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 1};
    // fill channel 1 with 3,2; refused push while full; steering to ch2 ready
    vecs[5]  = '{1, 0, 3, 0, 0,   1, 0, 0, 0, 0, 1, 1};
    vecs[6]  = '{1, 0, 2, 0, 0,   1, 1, 3, 0, 0, 2, 1};
    vecs[7]  = '{1, 0, 1, 0, 0,   0, 1, 3, 0, 0, 3, 1};
    vecs[8]  = '{0, 1, 0, 0, 0,   1, 1, 3, 0, 0, 3, 1};
    vecs[9]  = '{0, 0, 0, 1, 0,   0, 1, 3, 0, 0, 3, 1};
    vecs[10] = '{0, 0, 0, 0, 0,   1, 1, 2, 0, 0, 3, 1};
    // refill to full, then push+pop on full: pop wins, push refused
    vecs[11] = '{1, 0, 1, 0, 0,   1, 1, 2, 0, 0, 3, 1};
    vecs[12] = '{1, 0, 0, 1, 0,   0, 1, 2, 0, 0, 4, 1};
    vecs[13] = '{0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 4, 1};
    vecs[14] = '{0, 0, 0, 1, 0,   1, 1, 1, 0, 0, 4, 1};
    vecs[15] = '{0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 4, 1};
    // streaming through channel 2 with consumer always ready
    vecs[16] = '{1, 1, 0, 0, 1,   1, 0, 0, 0, 0, 4, 1};
    vecs[17] = '{1, 1, 1, 0, 1,   1, 0, 0, 1, 0, 4, 2};
    vecs[18] = '{1, 1, 2, 0, 1,   1, 0, 0, 1, 1, 4, 3};
    vecs[19] = '{1, 1, 3, 0, 1,   1, 0, 0, 1, 2, 4, 4};
    vecs[20] = '{1, 1, 0, 0, 1,   1, 0, 0, 1, 3, 4, 5};
    vecs[21] = '{1, 1, 1, 0, 1,   1, 0, 0, 1, 0, 4, 6};
    vecs[22] = '{0, 1, 0, 0, 1,   1, 0, 0, 1, 1, 4, 7};
    vecs[23] = '{0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 4, 7};

    // Reset state while rst_n is held low
    #12;
    check("reset In_ready",   int'(In_ready),   1);
    check("reset Out1_valid", int'(Out1_valid), 0);
    check("reset Out2_valid", int'(Out2_valid), 0);
    check("reset Out1_data",  int'(Out1_data),  0);
    check("reset Out2_data",  int'(Out2_data),  0);
    check("reset cnt1",       int'(cnt1),       0);
    check("reset cnt2",       int'(cnt2),       0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      In_valid   = 1'(vecs[i].iv);
      In_signal  = 1'(vecs[i].isig);
      In_data    = 2'(vecs[i].id);
      Out1_ready = 1'(vecs[i].r1);
      Out2_ready = 1'(vecs[i].r2);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset with channel 1 holding two items
    @(negedge clk);
    In_valid = 1'b1; In_signal = 1'b0; In_data = 2'd3;
    Out1_ready = 1'b0; Out2_ready = 1'b0;
    @(negedge clk);
    In_data = 2'd1;
    @(negedge clk);
    In_valid = 1'b0;
    #1;
    check("prereset Out1_valid", int'(Out1_valid), 1);
    check("prereset In_ready",   int'(In_ready),   0);
    check("prereset cnt1",       int'(cnt1),       6);
    #1 rst_n = 1'b0;
    #1;
    check("async Out1_valid", int'(Out1_valid), 0);
    check("async Out1_data",  int'(Out1_data),  0);
    check("async cnt1",       int'(cnt1),       0);
    check("async cnt2",       int'(cnt2),       0);
    check("async In_ready",   int'(In_ready),   1);
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release accepts
    In_valid = 1'b1; In_signal = 1'b1; In_data = 2'd2;
    @(negedge clk);
    In_valid = 1'b0;
    #1;
    check("postreset Out2_valid", int'(Out2_valid), 1);
    check("postreset Out2_data",  int'(Out2_data),  2);
    check("postreset cnt2",       int'(cnt2),       1);
    check("postreset Out1_valid", int'(Out1_valid), 0);

    // Counter wrap on 2-bit counters: five accepts with continuous pop
    @(negedge clk);
    b_Out1_ready = 1'b1; b_In_signal = 1'b0; b_In_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      b_In_data = 2'((k + 1) % 4);
      @(negedge clk);
    end
    b_In_valid = 1'b0;
    #1;
    check("wrap cnt1",       int'(b_cnt1),       1);
    check("wrap cnt2",       int'(b_cnt2),       0);
    check("wrap Out1_valid", int'(b_Out1_valid), 1);
    check("wrap Out1_data",  int'(b_Out1_data),  1);
    @(negedge clk);
    #1;
    check("wrap drained", int'(b_Out1_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_2bit_fifo.md
# demux_2bit_fifo

Routes a stream of 2-bit items from one producer to one of two consumer channels, selected per item by a 1-bit steering signal, and buffers each channel in its own small FIFO with valid/ready handshakes on every side. It is the splitting counterpart of the 2-bit two-input selector. One input stream fans out to two independently back-pressured outputs. Per-channel accept counters support status display and debug.

## Interface
- DEPTH, 2, entries per channel FIFO; power of two, ≥2
- CNT_W, 8, width of per-channel accept counters
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- In_data  input  2  item payload
- In_signal  input  1  steering: 0 → channel 1, 1 → channel 2; sampled with the item
- In_valid  input  1  producer offers item
- In_ready  output  1  selected channel can accept this cycle
- Out1_data  output  2  channel 1 head item
- Out1_valid  output  1  channel 1 non-empty
- Out1_ready  input  1  channel 1 consumer takes head
- Out2_data  output  2  channel 2 head item
- Out2_valid  output  1  channel 2 non-empty
- Out2_ready  input  1  channel 2 consumer takes head
- cnt1  output  CNT_W  items accepted into channel 1
- cnt2  output  CNT_W  items accepted into channel 2

## Operation
- Each channel is a circular FIFO with DEPTH entries.
  - Read/write pointers are log2(DEPTH) bits wide.
  - An occupancy counter of log2(DEPTH)+1 bits tracks fill level.
  - full = (occupancy == DEPTH); empty = (occupancy == 0).
- In_ready = !full of the channel selected by the current In_signal. It is combinational from In_signal and the FIFO state only, never from In_valid.
- Accept: In_valid && In_ready at a clock edge.
  - In_data is written at the selected channel's write pointer.
  - The write pointer increments and wraps from DEPTH-1 to 0.
  - The channel counter increments.
  - The other channel is untouched.
- Pop: Outx_valid && Outx_ready at a clock edge. The channel's read pointer increments and wraps.
- Outx_valid = !empty. Outx_data = entry at the read pointer when non-empty, 2'b00 when empty.
- Simultaneous push and pop on the same channel:
  - Occupancy is unchanged and both pointers advance.
  - This is legal only when the channel is not full, because In_ready reflects full with no pop bypass.
  - On a full channel the pop proceeds and the push is refused. In_ready rises on the following cycle.
- A push to channel 1 and a pop from channel 2 in the same cycle are fully independent.
- In_ready is low while the selected channel is full, even if the other channel has space. Steering is never altered by the block.
- Ordering: items leave each channel in acceptance order. There is no ordering guarantee between channels.
- Counters wrap modulo 2^CNT_W with no saturation.
- Outx_ready while empty has no effect.

## Timing
- Reset (rst_n low, asynchronous) clears pointers, occupancies and counters immediately:
  - Out1_valid = Out2_valid = 0.
  - Out1_data = Out2_data = 2'b00.
  - cnt1 = cnt2 = 0.
  - In_ready = 1.
- Reset assertion mid-operation discards all buffered items.
- Release of reset is synchronized by the system. The first accept can occur on the first edge after deassertion.
- Latency:
  - An item accepted at edge N appears on Outx_data with Outx_valid = 1 after edge N; it is poppable at edge N+1.
  - cntx reflects the accept after edge N.
- Throughput: one accept and up to two pops per cycle. A channel sustains one item per cycle while its consumer holds Outx_ready high.
- Storage is registered and no output depends combinationally on In_data or In_valid.

## Test plan
- Reset: hold rst_n low mid-stream with channel 1 holding 2 items → Out1_valid = 0 and cnt1 = 0 immediately, without waiting for an edge; In_ready = 1.
- Steering: push 2'b01 with In_signal = 0, then 2'b10 with In_signal = 1, both outputs ready=0 → Out1_data = 01 and Out2_data = 10, both valid, cnt1 = cnt2 = 1.
- Full: DEPTH=2, push 3, 2 to channel 1 with Out1_ready = 0 → In_ready = 0 for In_signal = 0 and 1 for In_signal = 1. Pop once → In_ready returns high next cycle and the head reads 3 then 2.
- Streaming wrap: Out2_ready = 1, push 0,1,2,3,0,1 to channel 2 on consecutive cycles → same sequence on Out2_data one cycle later. Out2_valid stays high throughout and cnt2 = 6.
- Full with simultaneous pop: channel 1 full, Out1_ready = 1 and In_valid = 1 in the same cycle → pop occurs, push refused, occupancy becomes 1, cnt1 is unchanged.
- Counter wrap: CNT_W=2, accept 5 items to channel 1 with continuous pop → cnt1 = 1.
